ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Parametrised, request/grant successor to the fixed-mode S-RAM mux. It arbitrates a single synchronous single-port RAM among NUM_DEVICES engines, such as the initializer, shuffler, decryptor and future key-search workers. Arbitration is round-robin with an optional hold limit. It tracks in-flight reads, so read data is returned to the device that issued each read even after ownership changes.

## Interface
- NUM_DEVICES, 3: number of requesting devices, ≥2.
- DATA_WIDTH, 8: RAM word width.
- ADDR_WIDTH, 8: RAM address width.
- RD_LATENCY, 1: RAM read latency in cycles, 1 or 2.
- MAX_HOLD, 0: maximum consecutive granted cycles while others wait. 0 means unlimited.
- OWNER_W, $clog2(NUM_DEVICES): width of the owner index (derived).
---
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high. Clears all state.
- req  in  NUM_DEVICES  per-device request. Held high for the whole transaction.
- dev_wren  in  NUM_DEVICES  per-device write enable.
- dev_addr  in  NUM_DEVICES×ADDR_WIDTH  per-device address.
- dev_wdata  in  NUM_DEVICES×DATA_WIDTH  per-device write data.
- grant  out  NUM_DEVICES  registered one-hot grant.
- dev_rvalid  out  NUM_DEVICES  one-cycle pulse: dev_rdata is valid for this device.
- dev_rdata  out  DATA_WIDTH  shared read-data return, equal to ram_rdata.
- ram_wren  out  1  RAM write enable.
- ram_addr  out  ADDR_WIDTH  RAM address.
- ram_wdata  out  DATA_WIDTH  RAM write data.
- ram_rdata  in  DATA_WIDTH  RAM read data.
- busy  out  1  a grant is active.
- owner  out  OWNER_W  index of the current grantee. Valid when busy=1.

## Operation
- States:
  - IDLE: no grant.
  - GRANT: exactly one grant bit set.
- Round-robin pointer rr_ptr (OWNER_W bits):
  - Search order is rr_ptr, rr_ptr+1, …, wrapping modulo NUM_DEVICES.
  - On every grant change, rr_ptr is set to the previous owner+1, with wrap: NUM_DEVICES-1 wraps to 0.
- IDLE → GRANT: at the edge where any req is high, grant the first requester in search order.
- GRANT, release: at the edge where req[owner]=0:
  - If any other req is high, grant the next requester from owner+1 directly, with no idle bubble.
  - Otherwise go to IDLE.
- GRANT, hold limit (MAX_HOLD>0):
  - hold_cnt counts granted cycles and resets on every new grant.
  - At the edge where hold_cnt=MAX_HOLD-1 and any other req is high, the grant is preempted to the next requester.
  - The preempted device sees its grant drop and keeps req high to be re-served later.
  - With no other requester, hold_cnt saturates and the grant continues.
- RAM mux (combinational from registered owner):
  - ram_addr = dev_addr[owner]
  - ram_wdata = dev_wdata[owner]
  - ram_wren = busy & req[owner] & dev_wren[owner]
  - In IDLE, all three are 0.
- Reads:
  - Every cycle with busy & req[owner] & !dev_wren[owner] is a read.
  - Each read enters a RD_LATENCY-deep pipeline tagged {valid, owner}.
  - At the output, dev_rvalid[tag] pulses for one cycle.
  - Tags survive grant changes: a read issued in a device's last granted cycle is still returned to that device.
- No writes are issued without a grant. A device must not drive dev_wren before it sees its own grant.

## Timing
- Reset values:
  - grant=0, busy=0, owner=0, dev_rvalid=0
  - ram_wren=0, ram_addr=0, ram_wdata=0
  - rr_ptr=0, hold_cnt=0, read pipeline cleared
- Request-to-grant latency: 1 cycle from IDLE. The device drives its first access in the first cycle grant is high.
- Release: the grant drops, or moves, one cycle after req[owner] is sampled low. ram_wren is already 0 in that cycle because it is gated by req.
- Read latency: dev_rvalid arrives exactly RD_LATENCY cycles after the read cycle. Throughput is one access per cycle.
- Simultaneous release and new requests: the new grant is issued at the same edge.
- Simultaneous preemption and release: treated as release.
- Reset mid-transaction: everything returns to reset values immediately. In-flight reads are discarded, and no dev_rvalid is issued afterwards.
- A req that drops before it is granted has no effect.

## Test plan
- Reset, then req=3'b001 held 4 cycles:
  - grant=001 one cycle later.
  - Device 0 writes addr 0x10 = 0xA5, then reads 0x10.
  - dev_rvalid[0] pulses RD_LATENCY cycles later with dev_rdata=0xA5.
  - After req drops, grant=000 and busy=0 next cycle.
- req=3'b111 held, each device releasing after 2 cycles:
  - Grant order is 0,1,2,0 with no idle cycles between grants.
  - rr_ptr wraps 2→0.
- MAX_HOLD=4, req=3'b011 held forever:
  - grant alternates 01/10 every 4 cycles.
  - With req=3'b001 only, grant stays on device 0 indefinitely.
- Device 1 reads in its last granted cycle, then releases while device 2 is waiting (RD_LATENCY=2):
  - dev_rvalid[1] pulses, not dev_rvalid[2], even though owner=2 at that time.
- reset asserted asynchronously mid-cycle with a read in flight:
  - grant, ram_wren and dev_rvalid are 0 immediately.
  - No rvalid follows deassertion.
  - The first grant after reset goes to the lowest-index requester.

Source files
------------

// File: rtl/ram_arbiter.sv
// Round-robin request/grant arbiter sharing one synchronous single-port RAM among
// NUM_DEVICES engines; read returns are tagged so they reach the issuing device.
module ram_arbiter #(
    parameter int NUM_DEVICES = 3,
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 8,
    parameter int RD_LATENCY  = 1,
    parameter int MAX_HOLD    = 0,
    parameter int OWNER_W     = $clog2(NUM_DEVICES)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_DEVICES-1:0]            req,
    input  logic [NUM_DEVICES-1:0]            dev_wren,
    input  logic [NUM_DEVICES*ADDR_WIDTH-1:0] dev_addr,
    input  logic [NUM_DEVICES*DATA_WIDTH-1:0] dev_wdata,
    output logic [NUM_DEVICES-1:0]            grant,
    output logic [NUM_DEVICES-1:0]            dev_rvalid,
    output logic [DATA_WIDTH-1:0]             dev_rdata,
    output logic                              ram_wren,
    output logic [ADDR_WIDTH-1:0]             ram_addr,
    output logic [DATA_WIDTH-1:0]             ram_wdata,
    input  logic [DATA_WIDTH-1:0]             ram_rdata,
    output logic                              busy,
    output logic [OWNER_W-1:0]                owner
);

    localparam int HOLD_LAST_I = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
    localparam int HOLD_W      = (HOLD_LAST_I > 0) ? $clog2(HOLD_LAST_I + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_LAST_I);
    localparam bit HOLD_EN = (MAX_HOLD > 0);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t                   state, state_nxt;
    logic [OWNER_W-1:0]       owner_nxt, rr_ptr, rr_ptr_nxt, owner_inc;
    logic [HOLD_W-1:0]        hold_cnt, hold_nxt;
    logic [NUM_DEVICES-1:0]   grant_nxt, owner_oh, others;
    logic                     own_req, own_wren, rd_issue;

    logic [RD_LATENCY-1:0]    rd_v;
    logic [OWNER_W-1:0]       rd_tag [RD_LATENCY];

    // First set bit of mask at or after start, wrapping; start itself if mask is empty.
    function automatic logic [OWNER_W-1:0] pick(input logic [NUM_DEVICES-1:0] mask,
                                                input logic [OWNER_W-1:0] start);
        logic               found;
        logic [OWNER_W-1:0] res;
        found = 1'b0;
        res   = start;
        for (int i = 0; i < NUM_DEVICES; i++) begin
            if (!found && mask[i] && (OWNER_W'(i) >= start)) begin
                found = 1'b1;
                res   = OWNER_W'(i);
            end
        end
        for (int i = 0; i < NUM_DEVICES; i++) begin
            if (!found && mask[i]) begin
                found = 1'b1;
                res   = OWNER_W'(i);
            end
        end
        return res;
    endfunction

    // busy is the state itself: the FSM is observable through busy/owner/grant.
    assign busy      = (state == GRANT);
    assign owner_inc = (owner == OWNER_W'(NUM_DEVICES - 1)) ? '0 : owner + OWNER_W'(1);

    always_comb begin
        owner_oh = '0;
        for (int i = 0; i < NUM_DEVICES; i++) begin
            owner_oh[i] = (owner == OWNER_W'(i));
        end
    end

    assign others   = req & ~owner_oh;
    assign own_req  = |(req & owner_oh);
    assign own_wren = |(dev_wren & owner_oh);

    // Handshake: a device raises req and holds it for the whole transaction; it may
    // access the RAM in every cycle its grant bit is high, and drops req to release.
    always_comb begin
        state_nxt  = state;
        owner_nxt  = owner;
        rr_ptr_nxt = rr_ptr;
        hold_nxt   = hold_cnt;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_nxt = GRANT;
                    owner_nxt = pick(req, rr_ptr);
                    hold_nxt  = '0;
                end
            end
            GRANT: begin
                if (!own_req) begin
                    rr_ptr_nxt = owner_inc;
                    hold_nxt   = '0;
                    if (|others) begin
                        owner_nxt = pick(others, owner_inc);
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (HOLD_EN && (hold_cnt == HOLD_LAST) && (|others)) begin
                    rr_ptr_nxt = owner_inc;
                    hold_nxt   = '0;
                    owner_nxt  = pick(others, owner_inc);
                end else if (hold_cnt != HOLD_LAST) begin
                    hold_nxt = hold_cnt + HOLD_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase

        grant_nxt = '0;
        for (int i = 0; i < NUM_DEVICES; i++) begin
            grant_nxt[i] = (state_nxt == GRANT) && (owner_nxt == OWNER_W'(i));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            owner    <= '0;
            rr_ptr   <= '0;
            hold_cnt <= '0;
            grant    <= '0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            rr_ptr   <= rr_ptr_nxt;
            hold_cnt <= hold_nxt;
            grant    <= grant_nxt;
        end
    end

    // RAM mux driven from the registered owner; writes are gated by the owner's req.
    always_comb begin
        ram_addr  = '0;
        ram_wdata = '0;
        ram_wren  = 1'b0;
        rd_issue  = 1'b0;
        if (busy) begin
            for (int i = 0; i < NUM_DEVICES; i++) begin
                if (owner == OWNER_W'(i)) begin
                    ram_addr  = dev_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                    ram_wdata = dev_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            ram_wren = own_req & own_wren;
            rd_issue = own_req & ~own_wren;
        end
    end

    // Read tags travel alongside the RAM's own latency so returns follow the issuer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_v <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                rd_tag[i] <= '0;
            end
        end else begin
            rd_v[0]   <= rd_issue;
            rd_tag[0] <= owner;
            for (int i = 1; i < RD_LATENCY; i++) begin
                rd_v[i]   <= rd_v[i-1];
                rd_tag[i] <= rd_tag[i-1];
            end
        end
    end

    always_comb begin
        dev_rvalid = '0;
        for (int i = 0; i < NUM_DEVICES; i++) begin
            dev_rvalid[i] = rd_v[RD_LATENCY-1] && (rd_tag[RD_LATENCY-1] == OWNER_W'(i));
        end
    end

    assign dev_rdata = ram_rdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter (3 devices, RD_LATENCY=2, MAX_HOLD=4) with a behavioural RAM,
// per-cycle grant expectations and a tagged read-return scoreboard.
module tb_ram_arbiter;

    localparam int N   = 3;
    localparam int DW  = 8;
    localparam int AW  = 8;
    localparam int RDL = 2;
    localparam int MH  = 4;
    localparam int OW  = 2;

    logic              clk;
    logic              reset;
    logic [N-1:0]      req;
    logic [N-1:0]      wren_v;
    logic [AW-1:0]     addr_v [N];
    logic [DW-1:0]     wdata_v [N];
    logic [N*AW-1:0]   dev_addr;
    logic [N*DW-1:0]   dev_wdata;
    logic [N-1:0]      grant;
    logic [N-1:0]      dev_rvalid;
    logic [DW-1:0]     dev_rdata;
    logic              ram_wren;
    logic [AW-1:0]     ram_addr;
    logic [DW-1:0]     ram_wdata;
    logic [DW-1:0]     ram_rdata;
    logic              busy;
    logic [OW-1:0]     owner;

    int checks = 0;
    int errors = 0;

    logic [N:0]        cyc_exp_q [$];   // {expected grant, expected ram_wren}
    logic [OW+DW-1:0]  rd_exp_q [$];    // {device, read data}

    logic [DW-1:0]     mem [256];
    logic [DW-1:0]     rd_p1, rd_p2;

    ram_arbiter #(
        .NUM_DEVICES(N),
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .RD_LATENCY (RDL),
        .MAX_HOLD   (MH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .dev_wren  (wren_v),
        .dev_addr  (dev_addr),
        .dev_wdata (dev_wdata),
        .grant     (grant),
        .dev_rvalid(dev_rvalid),
        .dev_rdata (dev_rdata),
        .ram_wren  (ram_wren),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .busy      (busy),
        .owner     (owner)
    );

    // clock / reset-free RAM model
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            dev_addr[i*AW +: AW]  = addr_v[i];
            dev_wdata[i*DW +: DW] = wdata_v[i];
        end
    end

    always @(posedge clk) begin
        if (ram_wren) mem[ram_addr] <= ram_wdata;
        rd_p1 <= mem[ram_addr];
        rd_p2 <= rd_p1;
    end
    assign ram_rdata = rd_p2;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int oh_idx(input logic [N-1:0] oh);
        int k;
        k = 0;
        for (int i = 0; i < N; i++) if (oh[i]) k = i;
        return k;
    endfunction

    // monitor
    always @(negedge clk) begin
        logic [N:0]       e;
        logic [OW+DW-1:0] r;
        int               k;
        if (cyc_exp_q.size() > 0) begin
            e = cyc_exp_q.pop_front();
            check("grant", 32'(grant), 32'(e[N:1]));
            check("busy", 32'(busy), 32'(|e[N:1]));
            check("ram_wren", 32'(ram_wren), 32'(e[0]));
            if (e[N:1] == '0) begin
                check("idle_addr", 32'(ram_addr), 32'd0);
                check("idle_wdata", 32'(ram_wdata), 32'd0);
            end else begin
                k = oh_idx(e[N:1]);
                check("owner", 32'(owner), 32'(k));
                check("ram_addr", 32'(ram_addr), 32'(addr_v[k]));
                check("ram_wdata", 32'(ram_wdata), 32'(wdata_v[k]));
            end
        end
        if (dev_rvalid != '0) begin
            if (rd_exp_q.size() == 0) begin
                check("rvalid_unexpected", 32'(dev_rvalid), 32'd0);
            end else begin
                r = rd_exp_q.pop_front();
                check("rvalid_dev", 32'(dev_rvalid), 32'(N'(1) << r[OW+DW-1:DW]));
                check("rdata", 32'(dev_rdata), 32'(r[DW-1:0]));
            end
        end
    end

    // driver tasks
    task automatic drive(input logic [N-1:0] r, input logic [N-1:0] w);
        req    = r;
        wren_v = w;
    endtask

    task automatic tick(input logic [N-1:0] eg, input logic ew);
        cyc_exp_q.push_back({eg, ew});
        @(posedge clk);
        #1;
    endtask

    task automatic expect_read(input int dev, input logic [DW-1:0] data);
        rd_exp_q.push_back({OW'(dev), data});
    endtask

    task automatic do_reset();
        drive(3'b000, 3'b000);
        repeat (3) tick(3'b000, 1'b0);
        check("drain", 32'(rd_exp_q.size()), 32'd0);
        reset = 1'b1;
        tick(3'b000, 1'b0);
        reset = 1'b0;
        tick(3'b000, 1'b0);
    endtask

    task automatic scen_single();
        addr_v[0]  = 8'h10;
        wdata_v[0] = 8'hA5;
        drive(3'b001, 3'b000); tick(3'b000, 1'b0);
        drive(3'b001, 3'b001); tick(3'b001, 1'b1);
        drive(3'b001, 3'b000); expect_read(0, 8'hA5); tick(3'b001, 1'b0);
        expect_read(0, 8'hA5); tick(3'b001, 1'b0);
        drive(3'b000, 3'b000); tick(3'b001, 1'b0);
        tick(3'b000, 1'b0);
    endtask

    task automatic scen_round_robin();
        addr_v[0] = 8'h20; wdata_v[0] = 8'h30;
        addr_v[1] = 8'h21; wdata_v[1] = 8'h31;
        addr_v[2] = 8'h22; wdata_v[2] = 8'h32;
        drive(3'b111, 3'b000); tick(3'b000, 1'b0);
        drive(3'b111, 3'b001); tick(3'b001, 1'b1);
        drive(3'b111, 3'b000); expect_read(0, 8'h30); tick(3'b001, 1'b0);
        drive(3'b110, 3'b000); tick(3'b001, 1'b0);
        drive(3'b110, 3'b010); tick(3'b010, 1'b1);
        drive(3'b110, 3'b000); expect_read(1, 8'h31); tick(3'b010, 1'b0);
        drive(3'b101, 3'b000); tick(3'b010, 1'b0);
        drive(3'b101, 3'b100); tick(3'b100, 1'b1);
        drive(3'b101, 3'b000); expect_read(2, 8'h32); tick(3'b100, 1'b0);
        drive(3'b001, 3'b000); tick(3'b100, 1'b0);
        expect_read(0, 8'h30); tick(3'b001, 1'b0);
        drive(3'b000, 3'b000); tick(3'b001, 1'b0);
        tick(3'b000, 1'b0);
    endtask

    task automatic scen_tag_handoff();
        drive(3'b110, 3'b000); tick(3'b000, 1'b0);
        expect_read(1, 8'h31); tick(3'b010, 1'b0);
        expect_read(1, 8'h31); tick(3'b010, 1'b0);
        drive(3'b100, 3'b000); tick(3'b010, 1'b0);
        expect_read(2, 8'h32); tick(3'b100, 1'b0);
        drive(3'b000, 3'b000); tick(3'b100, 1'b0);
        tick(3'b000, 1'b0);
    endtask

    task automatic scen_hold_limit();
        int d;
        drive(3'b011, 3'b000); tick(3'b000, 1'b0);
        for (int i = 0; i < 12; i++) begin
            d = (i / 4) % 2;
            drive((i >= 10) ? 3'b001 : 3'b011, 3'b000);
            expect_read(d, (d == 0) ? 8'h30 : 8'h31);
            tick((d == 0) ? 3'b001 : 3'b010, 1'b0);
        end
        for (int j = 0; j < 6; j++) begin
            expect_read(0, 8'h30); tick(3'b001, 1'b0);
        end
        drive(3'b011, 3'b000); expect_read(0, 8'h30); tick(3'b001, 1'b0);
        drive(3'b010, 3'b000); expect_read(1, 8'h31); tick(3'b010, 1'b0);
        drive(3'b000, 3'b000); tick(3'b010, 1'b0);
        tick(3'b000, 1'b0);
    endtask

    task automatic scen_async_reset();
        drive(3'b001, 3'b000); tick(3'b000, 1'b0);
        expect_read(0, 8'h30); tick(3'b001, 1'b0);
        drive(3'b001, 3'b001);
        reset = 1'b1;
        #1;
        check("rst_mid_grant", 32'(grant), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_wren", 32'(ram_wren), 32'd0);
        check("rst_mid_rvalid", 32'(dev_rvalid), 32'd0);
        rd_exp_q.delete();
        #2;
        reset = 1'b0;
        drive(3'b000, 3'b000);
        tick(3'b000, 1'b0);
        repeat (3) tick(3'b000, 1'b0);
        drive(3'b111, 3'b000); tick(3'b000, 1'b0);
        expect_read(0, 8'h30); tick(3'b001, 1'b0);
        drive(3'b000, 3'b000); tick(3'b001, 1'b0);
        repeat (3) tick(3'b000, 1'b0);
        check("final_drain", 32'(rd_exp_q.size()), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        drive(3'b111, 3'b111);
        for (int i = 0; i < N; i++) begin
            addr_v[i]  = 8'h55;
            wdata_v[i] = 8'h66;
        end
        @(posedge clk);
        #1;
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_owner", 32'(owner), 32'd0);
        check("rst_rvalid", 32'(dev_rvalid), 32'd0);
        check("rst_wren", 32'(ram_wren), 32'd0);
        check("rst_addr", 32'(ram_addr), 32'd0);
        check("rst_wdata", 32'(ram_wdata), 32'd0);
        tick(3'b000, 1'b0);
        drive(3'b000, 3'b000);
        reset = 1'b0;
        tick(3'b000, 1'b0);

        scen_single();
        do_reset();
        scen_round_robin();
        do_reset();
        scen_tag_handoff();
        do_reset();
        scen_hold_limit();
        scen_async_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
